// File: rtl/iter_alu.sv
// iter_alu: handshaked ALU with an IDLE/BUSY/DONE FSM; single-cycle ops finish in one cycle.
// Define ALU_MULDIV_EN to build the iterative shift-add multiply and restoring divide datapath.
module iter_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [3:0]       alu_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             illegal_op
);

   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1100;
   localparam logic [3:0] OP_SLT  = 4'b1101;
   localparam logic [3:0] OP_BEQ  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1111;
   localparam logic [3:0] OP_MUL  = 4'b0101;
   localparam logic [3:0] OP_DIVU = 4'b0110;
   localparam logic [3:0] OP_REMU = 4'b0111;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic signed [WIDTH-1:0] sa, sb;
   logic [WIDTH-1:0]        sum, dif, res_c, fin_c;
   logic                    zero_c, ovf_c, ill_c, busy_c;

   always_comb begin
      sa     = operand_a;
      sb     = operand_b;
      sum    = operand_a + operand_b;
      dif    = operand_a - operand_b;
      res_c  = '0;
      zero_c = 1'b0;
      ovf_c  = 1'b0;
      ill_c  = 1'b0;
      busy_c = 1'b0;
      case (alu_op)
         OP_ADD: begin
            res_c = sum;
            ovf_c = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) && (sum[WIDTH-1] != operand_a[WIDTH-1]);
         end
         OP_SUB: begin
            res_c = dif;
            ovf_c = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) && (dif[WIDTH-1] != operand_a[WIDTH-1]);
         end
         OP_AND:  res_c = operand_a & operand_b;
         OP_OR:   res_c = operand_a | operand_b;
         OP_SLTU: res_c = WIDTH'(operand_a < operand_b);
         OP_SLT:  res_c = WIDTH'(sa < sb);
         OP_BEQ:  zero_c = (operand_a == operand_b);
         OP_JMP:  zero_c = 1'b1;
`ifdef ALU_MULDIV_EN
         // Division by zero resolves immediately without entering BUSY
         OP_MUL:  busy_c = 1'b1;
         OP_DIVU: if (operand_b == '0) res_c = '1; else busy_c = 1'b1;
         OP_REMU: if (operand_b == '0) res_c = operand_a; else busy_c = 1'b1;
`endif
         default: ill_c = 1'b1;
      endcase
   end

`ifdef ALU_MULDIV_EN
   // mul: acc += a<<i when b[i]; div: acc is the partial remainder, a shifts into the quotient
   logic [WIDTH-1:0] a_q, b_q, acc_q, a_nxt, b_nxt, acc_nxt;
   logic [3:0]       op_q;
   logic [WIDTH:0]   rem_sh, rem_sub;

   always_comb begin
      rem_sh  = {acc_q, a_q[WIDTH-1]};
      rem_sub = rem_sh - {1'b0, b_q};
      b_nxt   = b_q;
      if (op_q == OP_MUL) begin
         acc_nxt = acc_q + (b_q[0] ? a_q : '0);
         a_nxt   = a_q << 1;
         b_nxt   = b_q >> 1;
      end else if (rem_sh >= {1'b0, b_q}) begin
         acc_nxt = WIDTH'(rem_sub);
         a_nxt   = {a_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_nxt = WIDTH'(rem_sh);
         a_nxt   = {a_q[WIDTH-2:0], 1'b0};
      end
      fin_c = (op_q == OP_DIVU) ? a_nxt : acc_nxt;
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         a_q   <= operand_a;
         b_q   <= operand_b;
         acc_q <= '0;
         op_q  <= alu_op;
      end else if (state == BUSY) begin
         a_q   <= a_nxt;
         b_q   <= b_nxt;
         acc_q <= acc_nxt;
      end
   end
`else
   assign fin_c = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         result     <= '0;
         zero       <= 1'b0;
         overflow   <= 1'b0;
         illegal_op <= 1'b0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               in_ready <= 1'b0;
               cnt      <= '0;
               if (busy_c) begin
                  state <= BUSY;
               end else begin
                  state      <= DONE;
                  out_valid  <= 1'b1;
                  result     <= res_c;
                  zero       <= zero_c;
                  overflow   <= ovf_c;
                  illegal_op <= ill_c;
               end
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH-1)) begin
                  state      <= DONE;
                  out_valid  <= 1'b1;
                  result     <= fin_c;
                  zero       <= 1'b0;
                  overflow   <= 1'b0;
                  illegal_op <= 1'b0;
               end
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_alu.sv
// Directed table-driven bench for iter_alu (WIDTH=32); muldiv expectations follow ALU_MULDIV_EN.
module tb_iter_alu;

   localparam int W = 32;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1100;
   localparam logic [3:0] OP_SLT  = 4'b1101;
   localparam logic [3:0] OP_BEQ  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1111;
   localparam logic [3:0] OP_MUL  = 4'b0101;
   localparam logic [3:0] OP_DIVU = 4'b0110;
   localparam logic [3:0] OP_REMU = 4'b0111;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] operand_a = '0;
   logic [W-1:0] operand_b = '0;
   logic [3:0]   alu_op = '0;
   logic         in_ready, out_valid, zero, overflow, illegal_op;
   logic [W-1:0] result;
   int           checks = 0;
   int           errors = 0;

   iter_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .overflow(overflow), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         z;
      logic         v;
      logic         ill;
      int           lat;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("in_ready wait", in_ready, 1);
      alu_op = op; operand_a = a; operand_b = b; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic ack();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      logic seen;

      vq.push_back(vec_t'{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1});
      vq.push_back(vec_t'{OP_ADD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1});
      vq.push_back(vec_t'{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1});
      vq.push_back(vec_t'{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1});
      vq.push_back(vec_t'{OP_SUB,  32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1});
      vq.push_back(vec_t'{OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 1'b0, 1});
      vq.push_back(vec_t'{OP_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0, 1'b0, 1});
      vq.push_back(vec_t'{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1});
      vq.push_back(vec_t'{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1});
      vq.push_back(vec_t'{OP_BEQ,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1});
      vq.push_back(vec_t'{OP_BEQ,  32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1});
      vq.push_back(vec_t'{OP_JMP,  32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1});
      vq.push_back(vec_t'{4'b0000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1});
      vq.push_back(vec_t'{4'b1110, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1});
`ifdef ALU_MULDIV_EN
      vq.push_back(vec_t'{OP_MUL,  32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 1'b0, 1'b0, 1'b0, W+1});
      vq.push_back(vec_t'{OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, W+1});
      vq.push_back(vec_t'{OP_DIVU, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 1'b0, W+1});
      vq.push_back(vec_t'{OP_REMU, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 1'b0, W+1});
      vq.push_back(vec_t'{OP_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1});
      vq.push_back(vec_t'{OP_REMU, 32'd9,         32'd0,         32'd9,         1'b0, 1'b0, 1'b0, 1});
`else
      vq.push_back(vec_t'{OP_MUL,  32'h0001_0000, 32'h0001_0003, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1});
      vq.push_back(vec_t'{OP_DIVU, 32'd100,       32'd7,         32'h0000_0000, 1'b0, 1'b0, 1'b1, 1});
      vq.push_back(vec_t'{OP_REMU, 32'd100,       32'd7,         32'h0000_0000, 1'b0, 1'b0, 1'b1, 1});
      vq.push_back(vec_t'{OP_DIVU, 32'd9,         32'd0,         32'h0000_0000, 1'b0, 1'b0, 1'b1, 1});
`endif

      // reset state
      repeat (2) @(negedge clk);
      chk("rst in_ready", in_ready, 1);
      chk("rst out_valid", out_valid, 0);
      chk("rst result", result, 0);
      chk("rst zero", zero, 0);
      chk("rst overflow", overflow, 0);
      chk("rst illegal_op", illegal_op, 0);
      rst_n = 1'b1;

      foreach (vq[i]) begin
         issue(vq[i].op, vq[i].a, vq[i].b);
         wait_out(lat);
         chk($sformatf("v%0d result", i), result, vq[i].res);
         chk($sformatf("v%0d zero", i), zero, vq[i].z);
         chk($sformatf("v%0d overflow", i), overflow, vq[i].v);
         chk($sformatf("v%0d illegal_op", i), illegal_op, vq[i].ill);
         chk($sformatf("v%0d latency", i), lat, vq[i].lat);
         ack();
         chk($sformatf("v%0d idle after ack", i), in_ready, 1);
      end

      // consumer stalls 10 cycles while a new request is offered
      issue(OP_ADD, 32'd5, 32'd3);
      wait_out(lat);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         alu_op = OP_ADD; operand_a = 32'd100; operand_b = 32'd1; in_valid = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("stall%0d out_valid", k), out_valid, 1);
         chk($sformatf("stall%0d result", k), result, 32'd8);
         chk($sformatf("stall%0d in_ready", k), in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("handshake no bypass out_valid", out_valid, 0);
      chk("handshake in_ready", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("post-stall accept out_valid", out_valid, 1);
      chk("post-stall accept result", result, 32'd101);
      ack();

      // reset ten cycles into an operation
`ifdef ALU_MULDIV_EN
      issue(OP_MUL, 32'h0001_0000, 32'h0001_0003);
`else
      issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
`endif
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midop rst in_ready", in_ready, 1);
      chk("midop rst out_valid", out_valid, 0);
      chk("midop rst result", result, 0);
      chk("midop rst zero", zero, 0);
      chk("midop rst overflow", overflow, 0);
      chk("midop rst illegal_op", illegal_op, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1 if (out_valid) seen = 1'b1;
      end
      chk("aborted op delivered", seen, 0);
      issue(OP_ADD, 32'd2, 32'd2);
      wait_out(lat);
      chk("after rst add result", result, 32'd4);
      chk("after rst add latency", lat, 1);
      ack();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port operand_a  input  WIDTH  source 1.
REQ-008 SHALL have port operand_b  input  WIDTH  source 2.
REQ-009 SHALL have port alu_op  input  4  function select.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  operation result.
REQ-013 SHALL have port zero  output  1  branch/jump condition flag.
REQ-014 SHALL have port overflow  output  1  signed overflow on add/sub.
REQ-015 SHALL have port illegal_op  output  1  unsupported alu_op flag.

Function
REQ-016 SHALL use FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 SHALL capture operand_a, operand_b, alu_op when in_valid&&in_ready; inputs ignored otherwise.
REQ-018 SHALL decode: 0001 add, 0011 sub, 0100 and, 1000 or, 1100 slt (unsigned, result 1/0), 1101 slt (signed), 1011 beq (zero=(a==b), result=0), 1111 jump (zero=1, result=0), 0101 mul low WIDTH bits, 0110 divu quotient, 0111 remu remainder.
REQ-019 SHALL for single-cycle ops go IDLE->DONE; out_valid asserted the cycle after acceptance (latency 1).
REQ-020 SHALL for mul go IDLE->BUSY, perform one shift-add step per cycle for WIDTH cycles, then DONE (latency WIDTH+1).
REQ-021 SHALL for divu/remu perform restoring division, one quotient bit per cycle, WIDTH cycles in BUSY, then DONE (latency WIDTH+1).
REQ-022 SHALL on divisor 0 skip BUSY: quotient all-ones, remainder = operand_a, latency 1.
REQ-023 SHALL wrap add/sub/mul modulo 2^WIDTH; overflow=1 only for add/sub when signed result sign is inconsistent with operand signs, else 0.
REQ-024 SHALL zero=0 for all ops except beq and jump.
REQ-025 SHALL on undefined alu_op: result=0, zero=0, illegal_op=1, latency 1.
REQ-026 SHALL hold result, zero, overflow, illegal_op stable in DONE until out_valid&&out_ready, then go IDLE.
REQ-027 SHALL not accept a new request in the handshake cycle of DONE (no bypass); next acceptance earliest one cycle later.

Reset
REQ-028 SHALL on rst_n=0 immediately force state IDLE, in_ready=1, out_valid=0, result=0, zero=0, overflow=0, illegal_op=0, counter=0.
REQ-029 SHALL abort any BUSY operation on reset mid-operation; no result delivered for it.

Configuration
REQ-030 SHALL compile mul/divu/remu datapath only when macro ALU_MULDIV_EN is defined.
REQ-031 SHALL without ALU_MULDIV_EN treat 0101, 0110, 0111 as undefined per REQ-025; BUSY state unreachable.

Verification
REQ-032 SHALL test add 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, out_valid one cycle after acceptance.
REQ-033 SHALL test beq 5,5 -> zero=1, result 0; beq 5,6 -> zero=0; slt signed 0xFFFFFFFF,1 -> 1; slt unsigned -> 0.
REQ-034 SHALL test mul 0x10000*0x10003 -> result 0x00030000, out_valid exactly 33 cycles after acceptance (WIDTH=32).
REQ-035 SHALL test divu 100/7 -> 14, remu 100/7 -> 2, divu 9/0 -> 0xFFFFFFFF latency 1.
REQ-036 SHALL test out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, no new capture.
REQ-037 SHALL test rst_n low at BUSY cycle 10 of mul -> immediate IDLE, all outputs 0, next add completes normally.
